// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
//   Byte-addressed, little-endian data memory behind a valid/ready request
//   and response handshake. Handles byte/half/word loads and stores with
//   sign or zero extension, a programmable read latency, and splitting of
//   word-crossing accesses into two array beats. Out-of-range accesses and
//   the illegal size code are reported through rsp_err without touching the
//   array. Array contents are undefined at power-up; reset does not clear them.
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         synchronous active-high reset
//   req_valid   request present
//   req_ready   controller idle and able to accept a request
//   req_write   1 = store, 0 = load
//   req_size    00 byte, 01 half, 10 word, 11 illegal
//   req_signed  sign-extend byte/half loads when 1
//   req_addr    byte address
//   req_wdata   store data, low 8/16/32 bits used
//   rsp_valid   response present
//   rsp_ready   consumer accepts the response
//   rsp_rdata   extended load data, 0 for stores and errors
//   rsp_err     out-of-range address or illegal size
//   tap_data    NTAP little-endian words starting at TAP_BASE
//
// State  | meaning
// IDLE   | waiting for a request, req_ready=1
// BEAT1  | access the bytes of word addr>>2
// BEAT2  | access the remaining bytes of word (addr>>2)+1
// LAT    | read latency countdown
// RESP   | response held until rsp_ready
module data_mem_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int DEPTH    = 65536,
  parameter int READ_LAT = 1,
  parameter int NTAP     = 2,
  parameter int TAP_BASE = 2000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [32*NTAP-1:0] tap_data
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, BEAT1, BEAT2, LAT, RESP} state_t;

  state_t           state, state_nx;
  logic [7:0]       mem [DEPTH];

  logic [IDX_W-1:0] addr_q;
  logic [1:0]       size_q;
  logic             write_q;
  logic             signed_q;
  logic             err_q;
  logic             cross_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rbuf;
  logic [2:0]       lat_cnt;

  logic [2:0]       req_len;
  logic [ADDR_W:0]  req_end;
  logic             req_err;
  logic             req_cross;
  logic             accept;
  logic [2:0]       len_q;
  logic [3:0]       lane_act;
  logic             in_beat;
  logic [31:0]      ext_data;

  // Request decode, evaluated on the raw request so it can steer IDLE.
  always_comb begin
    req_len = 3'd4;
    case (req_size)
      2'b00:   req_len = 3'd1;
      2'b01:   req_len = 3'd2;
      default: req_len = 3'd4;
    endcase
  end

  // One extra bit so addr+n cannot wrap before the range compare.
  assign req_end   = {1'b0, req_addr} + (ADDR_W+1)'(req_len);
  assign req_err   = (req_size == 2'b11) || (req_end > (ADDR_W+1)'(DEPTH));
  assign req_cross = ({2'b00, req_addr[1:0]} + {1'b0, req_len}) > 4'd4;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    len_q = 3'd4;
    case (size_q)
      2'b00:   len_q = 3'd1;
      2'b01:   len_q = 3'd2;
      default: len_q = 3'd4;
    endcase
  end

  // Transfer byte j lives in BEAT2 when it spills past lane 3 of the first word.
  assign in_beat = (state == BEAT1) || (state == BEAT2);
  always_comb begin
    lane_act = '0;
    for (int j = 0; j < 4; j++) begin
      lane_act[j] = in_beat && (3'(j) < len_q) &&
                    ((({1'b0, addr_q[1:0]} + 3'(j)) > 3'd3) == (state == BEAT2));
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (accept) state_nx = req_err ? RESP : BEAT1;
      BEAT1: begin
        if (cross_q)             state_nx = BEAT2;
        else if (write_q)        state_nx = RESP;
        else if (READ_LAT == 0)  state_nx = RESP;
        else                     state_nx = LAT;
      end
      BEAT2: begin
        if (write_q)             state_nx = RESP;
        else if (READ_LAT == 0)  state_nx = RESP;
        else                     state_nx = LAT;
      end
      LAT:   if (lat_cnt == 3'd0) state_nx = RESP;
      RESP:  if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lat_cnt <= 3'd0;
    end else begin
      state <= state_nx;
      // Down-counter loaded on LAT entry; terminal count 0 releases RESP.
      if (state != LAT && state_nx == LAT)
        lat_cnt <= 3'(READ_LAT - 1);
      else if (state == LAT && lat_cnt != 3'd0)
        lat_cnt <= lat_cnt - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q   <= req_addr[IDX_W-1:0];
      size_q   <= req_size;
      write_q  <= req_write;
      signed_q <= req_signed;
      wdata_q  <= req_wdata;
      err_q    <= req_err;
      cross_q  <= req_cross;
      rbuf     <= '0;
    end else if (!write_q) begin
      for (int j = 0; j < 4; j++)
        if (lane_act[j]) rbuf[8*j +: 8] <= mem[addr_q + IDX_W'(j)];
    end
  end

  // Writes are suppressed under reset so a reset in BEAT2 leaves only BEAT1 bytes.
  always_ff @(posedge clk) begin
    if (!rst && write_q) begin
      for (int j = 0; j < 4; j++)
        if (lane_act[j]) mem[addr_q + IDX_W'(j)] <= wdata_q[8*j +: 8];
    end
  end

  always_comb begin
    ext_data = rbuf;
    case (size_q)
      2'b00:   ext_data = {{24{signed_q & rbuf[7]}},  rbuf[7:0]};
      2'b01:   ext_data = {{16{signed_q & rbuf[15]}}, rbuf[15:0]};
      default: ext_data = rbuf;
    endcase
  end

  assign rsp_valid = (state == RESP);
  assign rsp_err   = (state == RESP) && err_q;
  assign rsp_rdata = (state == RESP && !err_q && !write_q) ? ext_data : 32'h0;

  for (genvar i = 0; i < NTAP; i++) begin : g_tap
    assign tap_data[32*i +: 32] = {mem[TAP_BASE + 4*i + 3], mem[TAP_BASE + 4*i + 2],
                                   mem[TAP_BASE + 4*i + 1], mem[TAP_BASE + 4*i]};
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

  localparam int DEPTH = 65536;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [63:0] tap_data;

  int checks = 0;
  int failures = 0;

  data_mem_ctrl #(
    .ADDR_W(32), .DEPTH(DEPTH), .READ_LAT(2), .NTAP(2), .TAP_BASE(2000)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .tap_data(tap_data)
  );

  always #5 clk = ~clk;

  // Issue one request with rsp_ready high. lat = rising edges after the
  // acceptance edge until rsp_valid is seen; -1 if it never came.
  task automatic do_txn(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    int guard = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd; rsp_ready = 1'b1;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    rd = rsp_rdata; er = rsp_err;
    if (!rsp_valid) begin
      lat = -1;
      checks++; failures++;
      $display("FAIL txn_timeout addr=%h got no rsp_valid, required rsp_valid=1", a);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    checks++;
    if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rsp_rdata got %h exp 0", rsp_rdata); end
    checks++;
    if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got %b exp 0", rsp_err); end
    checks++;
    rst = 1'b0;
    @(posedge clk); #1;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    checks++;
  endtask

  task automatic test_word_byte();
    logic [31:0] rd; logic er; int lat;
    logic        v_w   [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [1:0]  v_sz  [6] = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b01, 2'b01};
    logic        v_sg  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] v_a   [6] = '{32'h10, 32'h10, 32'h10, 32'h13, 32'h12, 32'h10};
    logic [31:0] v_exp [6] = '{32'h0, 32'hA1B2C3D4, 32'hFFFFFFD4, 32'h000000A1,
                               32'hFFFFA1B2, 32'h0000C3D4};
    int          v_lat [6] = '{1, 3, 3, 3, 3, 3};
    for (int i = 0; i < 6; i++) begin
      do_txn(v_w[i], v_sz[i], v_sg[i], v_a[i], 32'hA1B2C3D4, rd, er, lat);
      if (rd !== v_exp[i] || er !== 1'b0) begin
        failures++;
        $display("FAIL word_byte[%0d] got rdata=%h err=%b exp rdata=%h err=0", i, rd, er, v_exp[i]);
      end
      checks++;
      if (lat != v_lat[i]) begin
        failures++;
        $display("FAIL word_byte_lat[%0d] got %0d exp %0d", i, lat, v_lat[i]);
      end
      checks++;
    end
  endtask

  task automatic test_half();
    logic [31:0] rd; logic er; int lat;
    do_txn(1'b1, 2'b10, 1'b0, 32'h20, 32'h55667788, rd, er, lat);
    do_txn(1'b1, 2'b01, 1'b0, 32'h22, 32'hDEAD8001, rd, er, lat);
    do_txn(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, rd, er, lat);
    if (rd !== 32'hFFFF8001) begin failures++; $display("FAIL half_signed got %h exp ffff8001", rd); end
    checks++;
    do_txn(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, rd, er, lat);
    if (rd !== 32'h00008001) begin failures++; $display("FAIL half_unsigned got %h exp 00008001", rd); end
    checks++;
    do_txn(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat);
    if (rd !== 32'h80017788) begin failures++; $display("FAIL half_neighbours got %h exp 80017788", rd); end
    checks++;
  endtask

  task automatic test_cross();
    logic [31:0] rd; logic er; int lat;
    do_txn(1'b1, 2'b10, 1'b0, 32'h0C, 32'hCAFEBABE, rd, er, lat);
    do_txn(1'b1, 2'b10, 1'b0, 32'h0E, 32'h11223344, rd, er, lat);
    if (lat != 2 || er !== 1'b0) begin failures++; $display("FAIL cross_store_lat got %0d err=%b exp 2 err=0", lat, er); end
    checks++;
    do_txn(1'b0, 2'b00, 1'b0, 32'h0E, 32'h0, rd, er, lat);
    if (rd !== 32'h44) begin failures++; $display("FAIL cross_byte_0e got %h exp 00000044", rd); end
    checks++;
    do_txn(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, rd, er, lat);
    if (rd !== 32'h11) begin failures++; $display("FAIL cross_byte_11 got %h exp 00000011", rd); end
    checks++;
    do_txn(1'b0, 2'b10, 1'b0, 32'h0E, 32'h0, rd, er, lat);
    if (rd !== 32'h11223344) begin failures++; $display("FAIL cross_word_load got %h exp 11223344", rd); end
    checks++;
    if (lat != 4) begin failures++; $display("FAIL cross_load_lat got %0d exp 4", lat); end
    checks++;
    do_txn(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, rd, er, lat);
    if (rd !== 32'h3344BABE) begin failures++; $display("FAIL cross_word_0c got %h exp 3344babe", rd); end
    checks++;
    do_txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
    if (rd !== 32'hA1B21122) begin failures++; $display("FAIL cross_word_10 got %h exp a1b21122", rd); end
    checks++;
    do_txn(1'b0, 2'b01, 1'b0, 32'h0F, 32'h0, rd, er, lat);
    if (rd !== 32'h00002233 || lat != 4) begin
      failures++; $display("FAIL cross_half_0f got %h lat=%0d exp 00002233 lat=4", rd, lat);
    end
    checks++;
  endtask

  task automatic test_error();
    logic [31:0] rd; logic er; int lat;
    do_txn(1'b1, 2'b10, 1'b0, DEPTH - 4, 32'h01020304, rd, er, lat);
    do_txn(1'b1, 2'b10, 1'b0, DEPTH - 2, 32'hFFFFFFFF, rd, er, lat);
    if (er !== 1'b1 || rd !== 32'h0 || lat != 0) begin
      failures++; $display("FAIL err_range_store got err=%b rdata=%h lat=%0d exp err=1 rdata=0 lat=0", er, rd, lat);
    end
    checks++;
    do_txn(1'b0, 2'b10, 1'b0, DEPTH - 4, 32'h0, rd, er, lat);
    if (rd !== 32'h01020304 || er !== 1'b0) begin
      failures++; $display("FAIL err_mem_untouched got %h err=%b exp 01020304 err=0", rd, er);
    end
    checks++;
    do_txn(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, rd, er, lat);
    if (er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL err_size11 got err=%b rdata=%h exp err=1 rdata=0", er, rd); end
    checks++;
    do_txn(1'b0, 2'b00, 1'b0, DEPTH - 1, 32'h0, rd, er, lat);
    if (er !== 1'b0 || rd !== 32'h01) begin failures++; $display("FAIL err_last_byte got err=%b rdata=%h exp err=0 rdata=01", er, rd); end
    checks++;
    do_txn(1'b0, 2'b01, 1'b0, DEPTH - 1, 32'h0, rd, er, lat);
    if (er !== 1'b1) begin failures++; $display("FAIL err_half_last got err=%b exp 1", er); end
    checks++;
    do_txn(1'b0, 2'b00, 1'b0, 32'h0001_0010, 32'h0, rd, er, lat);
    if (er !== 1'b1) begin failures++; $display("FAIL err_high_addr got err=%b exp 1", er); end
    checks++;
  endtask

  task automatic test_backpressure();
    int guard = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h10; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    while (!rsp_valid && guard < 20) begin @(posedge clk); #1; guard++; end
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA1B21122 || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d] got valid=%b rdata=%h ready=%b exp valid=1 rdata=a1b21122 ready=0",
                 i, rsp_valid, rsp_rdata, req_ready);
      end
      checks++;
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release got valid=%b ready=%b exp valid=0 ready=1", rsp_valid, req_ready);
    end
    checks++;
  endtask

  task automatic test_tap();
    logic [31:0] rd; logic er; int lat;
    do_txn(1'b1, 2'b10, 1'b0, 32'd2000, 32'h12345678, rd, er, lat);
    do_txn(1'b1, 2'b10, 1'b0, 32'd2004, 32'h0, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 32'd2004; req_wdata = 32'h7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (tap_data[63:32] !== 32'h0) begin failures++; $display("FAIL tap_before_write got %h exp 0", tap_data[63:32]); end
    checks++;
    @(posedge clk); #1;
    if (tap_data[63:32] !== 32'h7) begin failures++; $display("FAIL tap1_after_write got %h exp 7", tap_data[63:32]); end
    checks++;
    if (tap_data[31:0] !== 32'h12345678) begin failures++; $display("FAIL tap0 got %h exp 12345678", tap_data[31:0]); end
    checks++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_beat2();
    logic [31:0] rd; logic er; int lat;
    do_txn(1'b1, 2'b10, 1'b0, 32'h2C, 32'h0, rd, er, lat);
    do_txn(1'b1, 2'b10, 1'b0, 32'h30, 32'h0, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 32'h2E; req_wdata = 32'hAABBCCDD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_beat2_valid got %b exp 0", rsp_valid); end
    checks++;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL rst_beat2_idle got valid=%b ready=%b exp valid=0 ready=1", rsp_valid, req_ready);
    end
    checks++;
    do_txn(1'b0, 2'b10, 1'b0, 32'h2C, 32'h0, rd, er, lat);
    if (rd !== 32'hCCDD0000) begin failures++; $display("FAIL rst_beat1_bytes got %h exp ccdd0000", rd); end
    checks++;
    do_txn(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, rd, er, lat);
    if (rd !== 32'h00000000) begin failures++; $display("FAIL rst_beat2_bytes got %h exp 00000000", rd); end
    checks++;
  endtask

  initial begin
    test_reset();
    test_word_byte();
    test_half();
    test_cross();
    test_error();
    test_backpressure();
    test_tap();
    test_reset_beat2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish, required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
